// File: rtl/line_code_pkg.sv
`default_nettype none
// ============================================================================
// Module  : line_code_pkg
// Purpose : Shared 8b/10b line-code definitions for the serial TX/RX path:
//           K28.5 idle code words, code-word width, transmission bit order,
//           the serializer state enum and a helper that reorders a packed
//           code word into line order.
// Revision: 1.0 - initial release
// ============================================================================
package line_code_pkg;

  localparam int unsigned c_CW_WIDTH = 10;

  // K28.5 in {f,g,h,j,a,b,c,d,e,i} packing
  localparam logic [c_CW_WIDTH-1:0] K28_5_NEG = 10'h28F;  // RD-, disparity +2
  localparam logic [c_CW_WIDTH-1:0] K28_5_POS = 10'h170;  // RD+, disparity -2

  // Packed-word index of each line bit, first transmitted bit first (a..j)
  localparam int unsigned c_TX_ORDER [c_CW_WIDTH] = '{5, 4, 3, 2, 1, 0, 9, 8, 7, 6};

  typedef enum logic [1:0] {
    SEND_DATA     = 2'd0,
    SEND_IDLE_NEG = 2'd1,
    SEND_IDLE_POS = 2'd2
  } line_state_t;

  // Result bit 0 is the first bit on the line.
  function automatic logic [c_CW_WIDTH-1:0] to_tx_order(input logic [c_CW_WIDTH-1:0] word);
    logic [c_CW_WIDTH-1:0] result;
    result = '0;
    for (int k = 0; k < c_CW_WIDTH; k++) begin
      result[k] = word[c_TX_ORDER[k]];
    end
    return result;
  endfunction

endpackage
`default_nettype wire

// File: rtl/serialize_10b_bit_tick_gen.sv
`default_nettype none
// ============================================================================
// Module  : bit_tick_gen
// Purpose : Bit-timing generator for a 10-bit serial word. clk_cnt runs
//           0..CLKS_PER_BIT-1, bit_cnt runs 0..BITS_PER_WORD-1 and advances
//           when clk_cnt wraps. Shared by the serializer and deserializer.
// Ports   : clk         - clock
//           rst         - asynchronous active-high reset (counters to 0)
//           o_bit_tick  - last clk of the current bit
//           o_last_tick - last clk of the last bit of the word
// Revision: 1.0 - initial release
// ============================================================================
module bit_tick_gen #(
  parameter int unsigned CLKS_PER_BIT  = 4,
  parameter int unsigned BITS_PER_WORD = 10
) (
  input  logic clk,
  input  logic rst,
  output logic o_bit_tick,
  output logic o_last_tick
);

  // A 1-bit counter is kept even when CLKS_PER_BIT=1; it then never leaves 0.
  localparam int unsigned c_CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned c_BIT_W = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
  localparam logic [c_CNT_W-1:0] c_CLK_MAX = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_BIT_W-1:0] c_BIT_MAX = c_BIT_W'(BITS_PER_WORD - 1);

  logic [c_CNT_W-1:0] r_clk_cnt;
  logic [c_BIT_W-1:0] r_bit_cnt;
  logic               w_bit_tick;
  logic               w_last_tick;

  assign w_bit_tick  = (r_clk_cnt == c_CLK_MAX);
  assign w_last_tick = w_bit_tick && (r_bit_cnt == c_BIT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else if (w_bit_tick) begin
      r_clk_cnt <= '0;
      r_bit_cnt <= w_last_tick ? '0 : r_bit_cnt + 1'b1;
    end else begin
      r_clk_cnt <= r_clk_cnt + 1'b1;
    end
  end

  assign o_bit_tick  = w_bit_tick;
  assign o_last_tick = w_last_tick;

endmodule
`default_nettype wire

// File: rtl/serialize_10b.sv
`default_nettype none
// ============================================================================
// Module  : serialize_10b
// Purpose : 8b/10b transmit line stage. Accepts 10-bit code words over a
//           valid/ready handshake and shifts them out at clk/CLKS_PER_BIT in
//           line order (a first, j last). With no word offered at a word
//           boundary it sends a K28.5 NEG/POS idle pair so the line never
//           stalls and running disparity stays balanced.
// Ports   : clk          - clock
//           rst          - asynchronous active-high reset
//           in_data      - code word {f,g,h,j,a,b,c,d,e,i}
//           in_valid     - in_data holds a word
//           in_ready     - word is taken this cycle (last clk of a word)
//           serial_out   - registered line bit
//           word_start   - pulse with the first bit of every word
//           word_is_idle - 1 while the current line word is an idle
//           underflow    - pulse when an idle pair directly follows data
// Revision: 1.0 - initial release
// ============================================================================
module serialize_10b
  import line_code_pkg::*;
#(
  parameter int unsigned     CLKS_PER_BIT = 4,        // 1..256
  parameter logic [9:0]      IDLE_NEG     = 10'h28F,
  parameter logic [9:0]      IDLE_POS     = 10'h170
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       serial_out,
  output logic       word_start,
  output logic       word_is_idle,
  output logic       underflow
);

  localparam logic [c_CW_WIDTH-1:0] c_IDLE_NEG_TX = to_tx_order(IDLE_NEG);
  localparam logic [c_CW_WIDTH-1:0] c_IDLE_POS_TX = to_tx_order(IDLE_POS);

  logic                  w_bit_tick;
  logic                  w_last_tick;
  logic [c_CW_WIDTH-1:0] w_data_tx;

  line_state_t           r_state;
  logic [c_CW_WIDTH-1:0] r_shift;       // bit 0 is the bit currently on the line
  logic                  r_serial;
  logic                  r_word_start;
  logic                  r_word_is_idle;
  logic                  r_underflow;

  bit_tick_gen #(
    .CLKS_PER_BIT  (CLKS_PER_BIT),
    .BITS_PER_WORD (c_CW_WIDTH)
  ) u_bit_tick_gen (
    .clk         (clk),
    .rst         (rst),
    .o_bit_tick  (w_bit_tick),
    .o_last_tick (w_last_tick)
  );

  assign w_data_tx = to_tx_order(in_data);

  // The second half of an idle pair is never pre-empted by data.
  assign in_ready = w_last_tick && (r_state != SEND_IDLE_NEG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= SEND_IDLE_NEG;
      r_shift        <= c_IDLE_NEG_TX;
      r_serial       <= c_IDLE_NEG_TX[0];
      r_word_start   <= 1'b0;
      r_word_is_idle <= 1'b1;
      r_underflow    <= 1'b0;
    end else begin
      r_word_start <= 1'b0;
      r_underflow  <= 1'b0;
      if (w_last_tick) begin
        // Word boundary: load the next word and present its first bit.
        r_word_start <= 1'b1;
        case (r_state)
          SEND_IDLE_NEG: begin
            r_state        <= SEND_IDLE_POS;
            r_shift        <= c_IDLE_POS_TX;
            r_serial       <= c_IDLE_POS_TX[0];
            r_word_is_idle <= 1'b1;
          end
          default: begin
            if (in_valid) begin
              r_state        <= SEND_DATA;
              r_shift        <= w_data_tx;
              r_serial       <= w_data_tx[0];
              r_word_is_idle <= 1'b0;
            end else begin
              r_state        <= SEND_IDLE_NEG;
              r_shift        <= c_IDLE_NEG_TX;
              r_serial       <= c_IDLE_NEG_TX[0];
              r_word_is_idle <= 1'b1;
              r_underflow    <= (r_state == SEND_DATA);
            end
          end
        endcase
      end else if (w_bit_tick) begin
        r_serial <= r_shift[1];
        r_shift  <= {1'b0, r_shift[c_CW_WIDTH-1:1]};
      end
    end
  end

  assign serial_out   = r_serial;
  assign word_start   = r_word_start;
  assign word_is_idle = r_word_is_idle;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire
